// File: rtl/load_sequencer.sv
// Load sequencer: streams host image and weight writes into the NPU RAMs, then launches inference.
// Optional feature: define LOAD_CHECKSUM_EN to add the load_sum running byte checksum output.
module load_sequencer #(
    parameter int IMG_WORDS = 224,
    parameter int W12_WORDS = 320,
    parameter int W34_WORDS = 9248,
    parameter int W5_WORDS  = 9248
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] control_reg,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        infer_done,
    output logic        img_we,
    output logic [7:0]  img_addr,
    output logic [31:0] img_wdata,
    output logic        w_we,
    output logic [1:0]  w_sel,
    output logic [13:0] w_addr,
    output logic [7:0]  w_wdata,
    output logic        start_infer,
    output logic        load_done,
    output logic        busy,
    output logic        cmd_err,
`ifdef LOAD_CHECKSUM_EN
    output logic [15:0] load_sum,
`endif
    output logic [2:0]  state
);

    // state  | meaning
    // IDLE   | waiting for a load command
    // LD_IMG | accepting image words
    // LD_W12 | accepting conv 1/2 weight bytes
    // LD_W34 | accepting conv 3/4 weight bytes
    // LD_W5  | accepting conv 5 weight bytes
    // READY  | everything loaded, waiting for infer command
    // INFER  | inference running, waiting for infer_done
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_IMG = 3'd1,
        S_LD_W12 = 3'd2,
        S_LD_W34 = 3'd3,
        S_LD_W5  = 3'd4,
        S_READY  = 3'd5,
        S_INFER  = 3'd6
    } state_t;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_INFER = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [13:0] IMG_LAST = 14'(IMG_WORDS - 1);
    localparam logic [13:0] W12_LAST = 14'(W12_WORDS - 1);
    localparam logic [13:0] W34_LAST = 14'(W34_WORDS - 1);
    localparam logic [13:0] W5_LAST  = 14'(W5_WORDS - 1);

    state_t      state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic        img_we_q, img_we_d;
    logic [7:0]  img_addr_q, img_addr_d;
    logic [31:0] img_wdata_q, img_wdata_d;
    logic        w_we_q, w_we_d;
    logic [1:0]  w_sel_q, w_sel_d;
    logic [13:0] w_addr_q, w_addr_d;
    logic [7:0]  w_wdata_q, w_wdata_d;
    logic        start_q, start_d;
    logic        load_done_q, load_done_d;
    logic        cmd_err_q, cmd_err_d;

    logic [1:0]  mode;
    logic        unused_ctrl;
    logic        in_load;
    logic        start_load;
    logic        accept;
    logic        cmd_fault;
    logic [13:0] phase_last;
    state_t      phase_next;
    logic [1:0]  phase_sel;

    assign mode        = control_reg[1:0];
    assign unused_ctrl = ^control_reg[31:2];

    always_comb begin
        in_load    = 1'b0;
        phase_last = '0;
        phase_next = S_IDLE;
        phase_sel  = 2'd0;
        case (state_q)
            S_LD_IMG: begin
                in_load    = 1'b1;
                phase_last = IMG_LAST;
                phase_next = S_LD_W12;
            end
            S_LD_W12: begin
                in_load    = 1'b1;
                phase_last = W12_LAST;
                phase_next = S_LD_W34;
                phase_sel  = 2'd0;
            end
            S_LD_W34: begin
                in_load    = 1'b1;
                phase_last = W34_LAST;
                phase_next = S_LD_W5;
                phase_sel  = 2'd1;
            end
            S_LD_W5: begin
                in_load    = 1'b1;
                phase_last = W5_LAST;
                phase_next = S_READY;
                phase_sel  = 2'd2;
            end
            default: begin
                in_load    = 1'b0;
                phase_last = '0;
                phase_next = S_IDLE;
                phase_sel  = 2'd0;
            end
        endcase
    end

    assign start_load = (state_q == S_IDLE) && (mode == MODE_LOAD);
    assign accept     = in_load && (mode != MODE_IDLE) && write;

    // Writes are only legal while a load phase is open; infer is only legal once loaded.
    assign cmd_fault = (mode == MODE_RSVD)
                    || ((mode == MODE_INFER) && (state_q != S_READY) && (state_q != S_INFER))
                    || (write && !in_load);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        img_we_d    = 1'b0;
        img_addr_d  = img_addr_q;
        img_wdata_d = img_wdata_q;
        w_we_d      = 1'b0;
        w_sel_d     = w_sel_q;
        w_addr_d    = w_addr_q;
        w_wdata_d   = w_wdata_q;
        start_d     = 1'b0;
        load_done_d = load_done_q;
        cmd_err_d   = cmd_err_q;

        if (cmd_fault) begin
            cmd_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    state_d     = S_LD_IMG;
                    cnt_d       = '0;
                    load_done_d = 1'b0;
                    cmd_err_d   = 1'b0;
                end
            end
            S_LD_IMG, S_LD_W12, S_LD_W34, S_LD_W5: begin
                if (mode == MODE_IDLE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (state_q == S_LD_IMG) begin
                        img_we_d    = 1'b1;
                        img_addr_d  = cnt_q[7:0];
                        img_wdata_d = writedata;
                    end else begin
                        w_we_d    = 1'b1;
                        w_sel_d   = phase_sel;
                        w_addr_d  = cnt_q;
                        w_wdata_d = writedata[7:0];
                    end
                    if (cnt_q == phase_last) begin
                        cnt_d   = '0;
                        state_d = phase_next;
                        if (phase_next == S_READY) begin
                            load_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 14'd1;
                    end
                end
            end
            S_READY: begin
                if (mode == MODE_INFER) begin
                    start_d = 1'b1;
                    state_d = S_INFER;
                end
            end
            S_INFER: begin
                if (infer_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            img_we_q    <= 1'b0;
            img_addr_q  <= '0;
            img_wdata_q <= '0;
            w_we_q      <= 1'b0;
            w_sel_q     <= '0;
            w_addr_q    <= '0;
            w_wdata_q   <= '0;
            start_q     <= 1'b0;
            load_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            img_we_q    <= img_we_d;
            img_addr_q  <= img_addr_d;
            img_wdata_q <= img_wdata_d;
            w_we_q      <= w_we_d;
            w_sel_q     <= w_sel_d;
            w_addr_q    <= w_addr_d;
            w_wdata_q   <= w_wdata_d;
            start_q     <= start_d;
            load_done_q <= load_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] entry_sum;

    // Image words contribute all four pixel bytes, weight entries only the low byte.
    always_comb begin
        if (state_q == S_LD_IMG) begin
            entry_sum = 16'(writedata[31:24]) + 16'(writedata[23:16])
                      + 16'(writedata[15:8])  + 16'(writedata[7:0]);
        end else begin
            entry_sum = {8'd0, writedata[7:0]};
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (start_load) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + entry_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign load_sum = sum_q;
`endif

    assign img_we      = img_we_q;
    assign img_addr    = img_addr_q;
    assign img_wdata   = img_wdata_q;
    assign w_we        = w_we_q;
    assign w_sel       = w_sel_q;
    assign w_addr      = w_addr_q;
    assign w_wdata     = w_wdata_q;
    assign start_infer = start_q;
    assign load_done   = load_done_q;
    assign busy        = in_load || (state_q == S_INFER);
    assign cmd_err     = cmd_err_q;
    assign state       = state_q;

endmodule
